// File: rtl/ip_frame_sequencer_pkg.sv
// IPv4 frame sequencer shared types and constants.
// Header beat numbering and IPv4 field values live here.
package ip_frame_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CHECK,
    PAYLOAD,
    DROP
  } state_t;

  localparam logic [3:0] IPV4_VERSION = 4'd4;
  localparam logic [3:0] IPV4_MIN_IHL = 4'd5;

  localparam logic [7:0] HDR_LAST_BEAT = 8'd4;
  localparam logic [7:0] PAYLOAD_FIRST_BEAT = 8'd5;
  localparam logic [7:0] BEAT_CNT_MAX = 8'd255;

  function automatic logic hdr_pass(
    input logic [3:0] ver,
    input logic [3:0] ihl,
    input logic [7:0] proto,
    input logic [7:0] want
  );
    return (ver == IPV4_VERSION) &&
           (ihl == IPV4_MIN_IHL) &&
           (proto == want);
  endfunction

endpackage

// File: rtl/ip_frame_sequencer_if.sv
// Bus bundle between MAC, header decoder, sequencer and parser.
// master = environment side, slave = sequencer side.
interface ip_frame_sequencer_if;

  logic [63:0] inData;
  logic        inValid;
  logic        inLast;
  logic        inReady;
  logic [2:0]  beatSel;
  logic [3:0]  hdrVersion;
  logic [3:0]  hdrLength;
  logic [7:0]  hdrProtocol;
  logic [63:0] outData;
  logic        outValid;
  logic        outLast;
  logic        outReady;
  logic [15:0] frameCount;
  logic [15:0] dropCount;
  logic [15:0] runtCount;

  modport master (
    output inData, inValid, inLast,
    output hdrVersion, hdrLength, hdrProtocol,
    output outReady,
    input  inReady, beatSel,
    input  outData, outValid, outLast,
    input  frameCount, dropCount, runtCount
  );

  modport slave (
    input  inData, inValid, inLast,
    input  hdrVersion, hdrLength, hdrProtocol,
    input  outReady,
    output inReady, beatSel,
    output outData, outValid, outLast,
    output frameCount, dropCount, runtCount
  );

endinterface

// File: rtl/ip_frame_sequencer.sv
// Walks MAC beats through IPv4 header, checks it once,
// then passes payload through or drops the frame.
module ip_frame_sequencer
  import ip_frame_sequencer_pkg::*;
#(
  parameter int MAX_BEATS = 8,
  parameter int IP_PROTO  = 17
) (
  input  logic clk,
  input  logic rstN,
  ip_frame_sequencer_if.slave bus
);

  localparam logic [7:0] SEL_MAX = 8'(MAX_BEATS - 1);
  localparam logic [7:0] PROTO   = 8'(IP_PROTO);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nx;
  logic [7:0]  cnt_inc;
  logic [7:0]  sel_sat;
  logic        armed;
  logic        ready;
  logic        xfer;
  logic        hdr_ok;
  logic        pay_beat;
  logic        inc_frame;
  logic        inc_drop;
  logic        inc_runt;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic [15:0] runt_cnt;

  assign hdr_ok = hdr_pass(bus.hdrVersion,
                           bus.hdrLength,
                           bus.hdrProtocol,
                           PROTO);

  // Ready per state; held low until first edge after reset.
  always_comb begin
    ready = 1'b0;
    unique case (state)
      IDLE:    ready = 1'b1;
      HDR:     ready = 1'b1;
      CHECK:   ready = 1'b0;
      PAYLOAD: ready = bus.outReady;
      DROP:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign bus.inReady = armed & ready;
  assign xfer = bus.inValid & bus.inReady;

  assign cnt_inc = (cnt == BEAT_CNT_MAX) ? cnt : cnt + 8'd1;
  assign sel_sat = (cnt > SEL_MAX) ? SEL_MAX : cnt;
  assign bus.beatSel = xfer ? 3'(sel_sat) : 3'd0;

  assign pay_beat     = (state == PAYLOAD) & bus.inValid;
  assign bus.outValid = pay_beat;
  assign bus.outLast  = pay_beat & bus.inLast;
  assign bus.outData  = pay_beat ? bus.inData : 64'd0;

  // Next state, beat counter and counter increment strobes.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    inc_frame = 1'b0;
    inc_drop  = 1'b0;
    inc_runt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (bus.inLast) begin
            inc_runt = 1'b1;
            cnt_nx   = 8'd0;
          end else begin
            state_nx = HDR;
            cnt_nx   = 8'd1;
          end
        end
      end
      HDR: begin
        if (xfer) begin
          if (bus.inLast) begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
            if (cnt < HDR_LAST_BEAT) begin
              inc_runt = 1'b1;
            end else if (hdr_ok) begin
              inc_frame = 1'b1;
            end else begin
              inc_drop = 1'b1;
            end
          end else if (cnt == HDR_LAST_BEAT) begin
            state_nx = CHECK;
            cnt_nx   = PAYLOAD_FIRST_BEAT;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      CHECK: begin
        if (hdr_ok) begin
          state_nx  = PAYLOAD;
          inc_frame = 1'b1;
        end else begin
          state_nx = DROP;
          inc_drop = 1'b1;
        end
      end
      PAYLOAD, DROP: begin
        if (xfer) begin
          if (bus.inLast) begin
            state_nx = IDLE;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // State register and beat counter.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Ready gate opens on the first edge after reset release.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Frame statistics, wrapping at 16 bits.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
      runt_cnt  <= 16'd0;
    end else begin
      if (inc_frame) frame_cnt <= frame_cnt + 16'd1;
      if (inc_drop)  drop_cnt  <= drop_cnt + 16'd1;
      if (inc_runt)  runt_cnt  <= runt_cnt + 16'd1;
    end
  end

  assign bus.frameCount = frame_cnt;
  assign bus.dropCount  = drop_cnt;
  assign bus.runtCount  = runt_cnt;

endmodule

// File: tb/tb_ip_frame_sequencer.sv
// Bench for ip_frame_sequencer: vector table, corner
// sequences and random frames against a frame-level model.
module tb_ip_frame_sequencer;

  localparam int MAXB = 8;
  localparam logic [7:0] PROTO = 8'd17;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  ip_frame_sequencer_if bus();

  ip_frame_sequencer #(
    .MAX_BEATS(MAXB),
    .IP_PROTO(17)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .bus(bus)
  );

  logic [3:0] dec_ver;
  logic [3:0] dec_len;
  logic [7:0] dec_proto;

  assign bus.hdrVersion  = dec_ver;
  assign bus.hdrLength   = dec_len;
  assign bus.hdrProtocol = dec_proto;

  // Header decoder stand-in: beat 2 byte0, beat 3 byte1.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dec_ver   <= 4'd0;
      dec_len   <= 4'd0;
      dec_proto <= 8'd0;
    end else if (bus.inValid && bus.inReady) begin
      if (bus.beatSel == 3'd2) begin
        dec_ver <= bus.inData[7:4];
        dec_len <= bus.inData[3:0];
      end
      if (bus.beatSel == 3'd3) begin
        dec_proto <= bus.inData[15:8];
      end
    end
  end

  typedef struct {
    logic [63:0] d;
    logic        l;
  } ob_t;

  typedef struct {
    int         n;
    logic [3:0] ver;
    logic [3:0] ihl;
    logic [7:0] proto;
    int         rmode;
    int         df;
    int         dd;
    int         dr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int m_frame = 0;
  int m_drop = 0;
  int m_runt = 0;
  ob_t q[$];
  logic [63:0] fb [16];
  vec_t tbl [11];

  task automatic chk(input string nm,
                     input logic [64:0] act,
                     input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_sel(input int k);
    int s;
    s = (k > MAXB - 1) ? MAXB - 1 : k;
    return 3'(s);
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_frameCount"}, bus.frameCount, 65'(16'(m_frame)));
    chk({tag, "_dropCount"}, bus.dropCount, 65'(16'(m_drop)));
    chk({tag, "_runtCount"}, bus.runtCount, 65'(16'(m_runt)));
  endtask

  task automatic release_reset();
    @(negedge clk);
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
    rstN = 1'b1;
    #1;
    chk("inReady_before_first_edge", bus.inReady, 0);
    @(posedge clk);
    #1;
    chk("inReady_after_first_edge", bus.inReady, 1);
    m_frame = 0;
    m_drop  = 0;
    m_runt  = 0;
    q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_inReady"}, bus.inReady, 0);
    chk({tag, "_beatSel"}, bus.beatSel, 0);
    chk({tag, "_outValid"}, bus.outValid, 0);
    chk({tag, "_outLast"}, bus.outLast, 0);
    chk({tag, "_outData"}, bus.outData, 0);
    chk({tag, "_frameCount"}, bus.frameCount, 0);
    chk({tag, "_dropCount"}, bus.dropCount, 0);
    chk({tag, "_runtCount"}, bus.runtCount, 0);
  endtask

  task automatic do_reset();
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.inValid = 1'b1;
    bus.inLast  = 1'b1;
    #1;
    chk_reset_outputs("reset");
    release_reset();
  endtask

  // vmode: 0 always valid, 1 random gaps.
  // rmode: 0 ready high, 1 pattern 1,0,0,1, 2 random.
  task automatic send_frame(input int n,
                            input logic [3:0] ver,
                            input logic [3:0] ihl,
                            input logic [7:0] proto,
                            input int vmode,
                            input int rmode,
                            input int abort_at);
    logic pass;
    logic v;
    logic xf;
    logic gap;
    logic exp_rdy;
    logic [3:0] pat;
    int k;
    int cyc;
    int rpat;
    ob_t e;
    pass = (ver == 4'd4) && (ihl == 4'd5) && (proto == PROTO);
    pat = 4'b1001;
    for (int i = 0; i < n; i++) begin
      fb[i] = {$urandom, $urandom};
      if (i == 2) fb[i][7:0] = {ver, ihl};
      if (i == 3) fb[i][15:8] = proto;
    end
    if (pass && n >= 6) begin
      for (int i = 5; i < n; i++) begin
        e.d = fb[i];
        e.l = (i == n - 1);
        q.push_back(e);
      end
    end
    k = 0;
    cyc = 0;
    rpat = 0;
    gap = 1'b0;
    while (k < n) begin
      if (cyc >= 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL frame_timeout: beat %0d of %0d", k, n);
        break;
      end
      cyc++;
      @(negedge clk);
      v = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      bus.inValid = v;
      bus.inData  = fb[k];
      bus.inLast  = v ? (k == n - 1) : 1'($urandom_range(0, 1));
      case (rmode)
        1: bus.outReady = pat[3 - (rpat % 4)];
        2: bus.outReady = 1'($urandom_range(0, 1));
        default: bus.outReady = 1'b1;
      endcase
      rpat++;
      if (k == abort_at) begin
        #1;
        rstN = 1'b0;
        #1;
        chk_reset_outputs("abort");
        q.delete();
        return;
      end
      #1;
      if (gap) exp_rdy = 1'b0;
      else if (k >= 5 && pass) exp_rdy = bus.outReady;
      else exp_rdy = 1'b1;
      chk("inReady", bus.inReady, 65'(exp_rdy));
      xf = v && bus.inReady;
      chk("beatSel", bus.beatSel, xf ? 65'(exp_sel(k)) : 65'd0);
      if (bus.outValid) begin
        if (q.size() == 0) begin
          chk("outValid_unexpected", bus.outValid, 0);
        end else begin
          chk("outData", bus.outData, 65'(q[0].d));
          chk("outLast", bus.outLast, 65'(q[0].l));
          if (bus.outReady) void'(q.pop_front());
        end
      end else begin
        chk("outIdle", {bus.outLast, bus.outData}, 0);
      end
      gap = 1'b0;
      if (xf) begin
        if (k == 4 && n >= 6) gap = 1'b1;
        k++;
      end
      @(posedge clk);
    end
    #1;
    chk("payload_all_delivered", 65'(q.size()), 0);
    q.delete();
    if (n <= 4) m_runt++;
    else if (pass) m_frame++;
    else m_drop++;
    chk_counters("frame");
  endtask

  int ef;
  int ed;
  int er;

  initial begin
    bus.inValid  = 1'b0;
    bus.inLast   = 1'b0;
    bus.inData   = 64'd0;
    bus.outReady = 1'b1;

    tbl[0]  = '{8, 4'd4, 4'd5, 8'h11, 0, 1, 0, 0};
    tbl[1]  = '{8, 4'd4, 4'd5, 8'h06, 0, 0, 1, 0};
    tbl[2]  = '{3, 4'd4, 4'd5, 8'h11, 0, 0, 0, 1};
    tbl[3]  = '{8, 4'd4, 4'd5, 8'h11, 0, 1, 0, 0};
    tbl[4]  = '{8, 4'd4, 4'd5, 8'h11, 1, 1, 0, 0};
    tbl[5]  = '{5, 4'd4, 4'd5, 8'h11, 0, 1, 0, 0};
    tbl[6]  = '{5, 4'd6, 4'd5, 8'h11, 0, 0, 1, 0};
    tbl[7]  = '{6, 4'd4, 4'd7, 8'h11, 0, 0, 1, 0};
    tbl[8]  = '{1, 4'd4, 4'd5, 8'h11, 0, 0, 0, 1};
    tbl[9]  = '{4, 4'd4, 4'd5, 8'h11, 0, 0, 0, 1};
    tbl[10] = '{12, 4'd4, 4'd5, 8'h11, 2, 1, 0, 0};

    do_reset();

    ef = 0;
    ed = 0;
    er = 0;
    for (int i = 0; i < 11; i++) begin
      send_frame(tbl[i].n, tbl[i].ver, tbl[i].ihl,
                 tbl[i].proto, 0, tbl[i].rmode, -1);
      ef += tbl[i].df;
      ed += tbl[i].dd;
      er += tbl[i].dr;
      chk("tbl_frameCount", bus.frameCount, 65'(16'(ef)));
      chk("tbl_dropCount", bus.dropCount, 65'(16'(ed)));
      chk("tbl_runtCount", bus.runtCount, 65'(16'(er)));
    end

    for (int i = 0; i < 40; i++) begin
      logic [3:0] rv;
      logic [3:0] ri;
      logic [7:0] rp;
      if ($urandom_range(0, 1) == 0) begin
        rv = 4'd4;
        ri = 4'd5;
        rp = PROTO;
      end else begin
        rv = 4'($urandom_range(3, 6));
        ri = 4'($urandom_range(4, 6));
        rp = ($urandom_range(0, 1) == 0) ? PROTO : 8'h06;
      end
      send_frame($urandom_range(1, 12), rv, ri, rp,
                 1, 2, -1);
    end

    send_frame(8, 4'd4, 4'd5, 8'h11, 0, 0, 6);
    repeat (2) @(posedge clk);
    release_reset();
    send_frame(8, 4'd4, 4'd5, 8'h11, 0, 0, -1);
    chk("after_abort_frameCount", bus.frameCount, 1);

    do_reset();
    for (int i = 0; i < 65535; i++) begin
      @(negedge clk);
      bus.inValid = 1'b1;
      bus.inLast  = 1'b1;
    end
    @(negedge clk);
    bus.inValid = 1'b0;
    #1;
    chk("runt_ffff", bus.runtCount, 65'h0FFFF);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.inValid = 1'b1;
      @(negedge clk);
      bus.inValid = 1'b0;
      #1;
      chk("runt_wrap", bus.runtCount, 65'(i));
    end
    chk("wrap_frameCount", bus.frameCount, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
